// File: rtl/binary_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding and
// nibble constants used by the double-dabble datapath.
package binary_to_bcd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] NIBBLE_NINE = 4'h9;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-nibble conditional add-3 of the shift-and-add-3 algorithm.
// The sum wraps within 4 bits; no carry leaves the nibble.
module bcd_add3
    import binary_to_bcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = nibble;
        if (nibble >= ADD3_THRESH) begin
            adjusted = nibble + 4'd3;
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter: one shift per clock, fixed IN_W-cycle
// latency, saturating to all nines when the input does not fit in DIGITS.
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0] BCD_MAX = IN_W'(pow10(DIGITS) - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [IN_W-1:0]         shift_q;
    logic [BCD_W-1:0]        scratch_q;
    logic                    ovf_q;
    logic [BCD_W-1:0]        adjusted;
    logic [BCD_W+IN_W-1:0]   joined;
    logic                    load;
    logic                    step;
    logic                    finish;

    function automatic logic [BCD_W-1:0] saturate(input logic ovf,
                                                  input logic [BCD_W-1:0] val);
        return ovf ? {DIGITS{NIBBLE_NINE}} : val;
    endfunction

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble   (scratch_q[4*d +: 4]),
            .adjusted (adjusted[4*d +: 4])
        );
    end

    // Adjusted scratch and remaining input bits shift together as one word.
    assign joined = {adjusted, shift_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= finish;
            busy <= (busy | load) & ~finish;
            if (load) begin
                shift_q   <= bin_in;
                scratch_q <= '0;
                cnt_q     <= CNT_W'(IN_W);
                ovf_q     <= (bin_in > BCD_MAX);
            end else if (step) begin
                scratch_q <= joined[BCD_W+IN_W-1:IN_W];
                shift_q   <= joined[IN_W-1:0];
                cnt_q     <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                bcd_out  <= saturate(ovf_q, joined[BCD_W+IN_W-1:IN_W]);
                overflow <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: stimulus queues expected results,
// a monitor pops and compares on every done pulse.
module tb_binary_to_bcd;

    localparam int IN_W   = 14;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    binary_to_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'h9999;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("busy_low_in_done_cycle", 32'(busy), 32'(0));
            check("done_width_one", 32'(prev_done), 32'(0));
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
                check("overflow", 32'(overflow), 32'(mon_e.ovf));
                check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        prev_done = rst_n ? done : 1'b0;
    end

    task automatic issue(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        start  = 1'b1;
        bin_in = 14'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{exp_bcd, exp_ovf, cyc + IN_W});
        check("busy_after_accept", 32'(busy), 32'(1));
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done within 40 cycles, expected one", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int v;
        #3;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_bcd", 32'(bcd_out), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(0, 16'h0000, 1'b0);
        wait_done("zero");
        @(posedge clk);
        #1;

        issue(1234, 16'h1234, 1'b0);
        wait_done("b2b_first");
        issue(9999, 16'h9999, 1'b0);
        wait_done("b2b_second");
        repeat (3) @(posedge clk);
        #1;
        check("hold_bcd", 32'(bcd_out), 32'h9999);

        issue(10000, 16'h9999, 1'b1);
        wait_done("ovf_10000");
        issue(16383, 16'h9999, 1'b1);
        wait_done("ovf_16383");
        issue(42, 16'h0042, 1'b0);
        wait_done("after_ovf");
        repeat (3) @(posedge clk);
        #1;
        check("hold_ovf_clear", 32'(overflow), 32'(0));
        check("hold_bcd_42", 32'(bcd_out), 32'h0042);

        // Re-pulse start and disturb bin_in while busy
        issue(5678, 16'h5678, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        bin_in = 14'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        bin_in = 14'd16383;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin_in = '0;
        wait_done("repulse");
        repeat (20) @(posedge clk);
        #1;
        check("repulse_idle", 32'(busy), 32'(0));
        check("repulse_bcd", 32'(bcd_out), 32'h5678);

        // Reset mid-conversion
        issue(777, 16'h0777, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_bcd", 32'(bcd_out), 32'(0));
        check("midrst_ovf", 32'(overflow), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("midrst_no_resume", 32'(busy), 32'(0));
        issue(321, 16'h0321, 1'b0);
        wait_done("after_reset");

        // Back-to-back sweep against the division-based model
        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(0, 16383));
            if (i == 0) v = 9999;
            if (i == 1) v = 10000;
            if (i == 2) v = 9;
            issue(v, ref_bcd(v), (v > 9999));
            wait_done("sweep");
        end

        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
